// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: frame constants, deframer states and the parity helper.
// Also used by the host-to-device transmitter.
package ps2_pkg;

  localparam logic PS2_START      = 1'b0;
  localparam logic PS2_STOP       = 1'b1;
  localparam int   PS2_FRAME_BITS = 11;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    CHECK
  } rx_state_t;

  // True when the eight data bits plus the parity bit carry an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_rx_fifo_if.sv
// Consumer-side bundle of the PS/2 receiver: pop handshake, error controls and status.
interface ps2_rx_fifo_if #(
  parameter int FIFO_AW = 3
);
  logic               nextdata_n;
  logic               clr_err;
  logic [7:0]         data;
  logic               ready;
  logic [FIFO_AW:0]   count;
  logic               overflow;
  logic               parity_err;
  logic               frame_err;

  modport master (
    output nextdata_n, clr_err,
    input  data, ready, count, overflow, parity_err, frame_err
  );

  modport slave (
    input  nextdata_n, clr_err,
    output data, ready, count, overflow, parity_err, frame_err
  );
endinterface

// File: rtl/ps2_sync_filter.sv
// PS/2 pin front end: synchronises both pins, deglitches the clock and emits a
// one-cycle strobe with the sampled data bit on every filtered falling edge.
module ps2_sync_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4
) (
  input  logic clk,
  input  logic clrn,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic strobe,
  output logic sample
);

  localparam int CW = $clog2(FILTER_LEN) + 1;

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] dat_sync;
  logic                   clk_filt;
  logic [CW-1:0]          stable_cnt;
  logic                   settle;
  logic                   fall;

  // The synchronised clock has disagreed with the filtered level long enough to flip it.
  assign settle = (clk_sync[SYNC_STAGES-1] != clk_filt) && (stable_cnt == CW'(FILTER_LEN - 1));
  assign fall   = settle && clk_filt;

  // NOTE: every register here uses <= so all flops update from pre-edge values,
  // which is what makes the synchroniser chain shift by exactly one stage per clock.
  always_ff @(posedge clk or posedge clrn) begin
    if (clrn) begin
      clk_sync   <= '1;
      dat_sync   <= '1;
      clk_filt   <= 1'b1;
      stable_cnt <= '0;
      strobe     <= 1'b0;
      sample     <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      dat_sync <= {dat_sync[SYNC_STAGES-2:0], ps2_data};
      if (settle) begin
        clk_filt   <= clk_sync[SYNC_STAGES-1];
        stable_cnt <= '0;
      end else if (clk_sync[SYNC_STAGES-1] != clk_filt) begin
        stable_cnt <= stable_cnt + 1'b1;
      end else begin
        stable_cnt <= '0;
      end
      strobe <= fall;
      if (fall) sample <= dat_sync[SYNC_STAGES-1];
    end
  end

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: deframes 11-bit frames, checks start/stop/parity,
// guards frames with a watchdog and queues good bytes in a power-of-two FIFO.
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int FIFO_AW        = 3,
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic          clk,
  input  logic          clrn,
  input  logic          ps2_clk,
  input  logic          ps2_data,
  ps2_rx_fifo_if.slave  bus
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int WDW   = $clog2(TIMEOUT_CYCLES) + 1;

  logic strobe;
  logic bit_in;

  ps2_sync_filter #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILTER_LEN  (FILTER_LEN)
  ) u_front (
    .clk      (clk),
    .clrn     (clrn),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .strobe   (strobe),
    .sample   (bit_in)
  );

  rx_state_t      state;
  logic [3:0]     bitcnt;
  logic [8:0]     shreg;      // {parity, data[7:0]} once all nine bits are in
  logic [WDW-1:0] wd;

  logic check_stb, stop_ok, par_ok, good, stop_bad, par_bad, timeout;

  assign check_stb = strobe && (state == CHECK);
  assign stop_ok   = (bit_in == PS2_STOP);
  assign par_ok    = odd_parity_ok(shreg[7:0], shreg[8]);
  assign good      = check_stb && stop_ok && par_ok;
  assign stop_bad  = check_stb && !stop_ok;
  assign par_bad   = check_stb && stop_ok && !par_ok;
  assign timeout   = (state != IDLE) && !strobe && (wd == WDW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge clrn) begin
    if (clrn) begin
      state  <= IDLE;
      bitcnt <= '0;
      shreg  <= '0;
      wd     <= '0;
    end else begin
      if (state == IDLE || strobe) wd <= '0;
      else                         wd <= wd + 1'b1;
      case (state)
        IDLE: begin
          if (strobe && bit_in == PS2_START) begin
            state  <= SHIFT;
            bitcnt <= '0;
          end
        end
        SHIFT: begin
          if (timeout) begin
            state <= IDLE;
          end else if (strobe) begin
            shreg  <= {bit_in, shreg[8:1]};   // LSB first: bit 0 ends at shreg[0]
            bitcnt <= bitcnt + 1'b1;
            if (bitcnt == 4'(PS2_FRAME_BITS - 3)) state <= CHECK;
          end
        end
        CHECK: begin
          if (timeout || strobe) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic [7:0]       mem [DEPTH];
  logic [FIFO_AW:0] wptr, rptr;
  logic             empty, full, do_pop, do_push, drop;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[FIFO_AW] != rptr[FIFO_AW]) &&
                   (wptr[FIFO_AW-1:0] == rptr[FIFO_AW-1:0]);
  assign do_pop  = !bus.nextdata_n && !empty;
  assign do_push = good && (!full || do_pop);
  assign drop    = good && full && !do_pop;

  always_ff @(posedge clk or posedge clrn) begin
    if (clrn) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  // NOTE: the storage array has no reset; the pointers alone define which entries
  // are valid, and leaving it unreset lets it map onto plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[FIFO_AW-1:0]] <= shreg[7:0];
  end

  always_ff @(posedge clk or posedge clrn) begin
    if (clrn) begin
      bus.overflow   <= 1'b0;
      bus.parity_err <= 1'b0;
      bus.frame_err  <= 1'b0;
    end else begin
      if (drop)                    bus.overflow   <= 1'b1;
      else if (bus.clr_err)        bus.overflow   <= 1'b0;
      if (par_bad)                 bus.parity_err <= 1'b1;
      else if (bus.clr_err)        bus.parity_err <= 1'b0;
      if (stop_bad || timeout)     bus.frame_err  <= 1'b1;
      else if (bus.clr_err)        bus.frame_err  <= 1'b0;
    end
  end

  assign bus.data  = mem[rptr[FIFO_AW-1:0]];
  assign bus.ready = !empty;
  assign bus.count = wptr - rptr;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Self-checking bench for ps2_rx_fifo: bit-banged PS/2 frames, byte scoreboard,
// error flags, glitch rejection, watchdog, overflow and mid-frame reset.
module tb_ps2_rx_fifo;

  localparam int AW   = 3;
  localparam int HALF = 16;
  localparam int TMO  = 1000;

  logic clk = 1'b0;
  logic clrn, ps2_clk, ps2_data;
  always #5 clk = ~clk;

  ps2_rx_fifo_if #(.FIFO_AW(AW)) bus ();

  ps2_rx_fifo #(
    .FIFO_AW        (AW),
    .SYNC_STAGES    (2),
    .FILTER_LEN     (4),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk      (clk),
    .clrn     (clrn),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .bus      (bus)
  );

  int         errors   = 0;
  int         checks   = 0;
  int         push_lat = -1;
  logic [7:0] exp_q[$];

  function automatic logic odd_par(input logic [7:0] b);
    return ~^b;
  endfunction

  function automatic logic [10:0] mk(input logic [7:0] b, input logic par, input logic stop);
    return {stop, par, b, 1'b0};
  endfunction

  // Drives frame bits first..last; optional 2-cycle clock glitch after bit glitch_bit
  // and optional one-cycle pop at cycle pop_at of the stop-bit low phase.
  task automatic send_bits(input logic [10:0] bits, input int first, input int last,
                           input int glitch_bit, input int pop_at);
    logic [AW:0] cnt0;
    cnt0 = bus.count;
    for (int i = first; i <= last; i++) begin
      ps2_data = bits[i];
      repeat (HALF/2) @(negedge clk);
      ps2_clk = 1'b0;
      for (int c = 0; c < HALF; c++) begin
        bus.nextdata_n = !(i == 10 && c == pop_at);
        @(negedge clk);
        if (i == 10 && push_lat < 0 && bus.count !== cnt0) push_lat = c + 1;
      end
      bus.nextdata_n = 1'b1;
      ps2_clk = 1'b1;
      for (int c = 0; c < HALF/2; c++) begin
        if (i == glitch_bit && c == 2) ps2_clk = 1'b0;
        if (i == glitch_bit && c == 4) ps2_clk = 1'b1;
        @(negedge clk);
      end
    end
    ps2_data = 1'b1;
    repeat (2*HALF) @(negedge clk);
  endtask

  task automatic send_good(input logic [7:0] b);
    send_bits(mk(b, odd_par(b), 1'b1), 0, 10, -1, -1);
    exp_q.push_back(b);
  endtask

  task automatic pop_one(input string name);
    logic [7:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++; $display("FAIL %s: scoreboard empty, ready=%0b", name, bus.ready);
    end else begin
      e = exp_q.pop_front();
      if (bus.ready !== 1'b1 || bus.data !== e) begin
        errors++; $display("FAIL %s: ready=%0b data=%h, required ready=1 data=%h", name, bus.ready, bus.data, e);
      end
    end
    bus.nextdata_n = 1'b0;
    @(negedge clk);
    bus.nextdata_n = 1'b1;
  endtask

  task automatic pulse_clr();
    bus.clr_err = 1'b1;
    @(negedge clk);
    bus.clr_err = 1'b0;
  endtask

  task automatic check_status(input string name, input logic [AW:0] cnt, input logic [2:0] flags);
    checks++;
    if (bus.count !== cnt || bus.ready !== (cnt != 0) ||
        {bus.overflow, bus.parity_err, bus.frame_err} !== flags) begin
      errors++;
      $display("FAIL %s: count=%0d ready=%0b {ovf,par,frm}=%b, required count=%0d ready=%0b flags=%b",
               name, bus.count, bus.ready, {bus.overflow, bus.parity_err, bus.frame_err},
               cnt, (cnt != 0), flags);
    end
  endtask

  task automatic test_reset();
    clrn = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1;
    bus.nextdata_n = 1'b1; bus.clr_err = 1'b0;
    repeat (3) @(negedge clk);
    clrn = 1'b0;
    repeat (3) @(negedge clk);
    check_status("reset", 0, 3'b000);
  endtask

  task automatic test_single();
    send_good(8'h1C);
    check_status("single_after_push", 1, 3'b000);
    pop_one("single_data");
    check_status("single_after_pop", 0, 3'b000);
    checks++;
    if (push_lat < 1) begin
      errors++; $display("FAIL push_latency: measured=%0d, required >=1", push_lat);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] e;
    send_good(8'hF0);
    send_good(8'h1C);
    send_good(8'hE0);
    check_status("b2b_count", 3, 3'b000);
    for (int k = 0; k < 3; k++) begin
      e = exp_q.pop_front();
      checks++;
      if (bus.ready !== 1'b1 || bus.data !== e) begin
        errors++; $display("FAIL b2b_drain%0d: ready=%0b data=%h, required ready=1 data=%h", k, bus.ready, bus.data, e);
      end
      bus.nextdata_n = 1'b0;
      @(negedge clk);
    end
    bus.nextdata_n = 1'b1;
    check_status("b2b_drained", 0, 3'b000);
  endtask

  task automatic test_parity();
    send_bits(mk(8'h1C, 1'b1, 1'b1), 0, 10, -1, -1);
    check_status("parity_bad", 0, 3'b010);
    send_good(8'h55);
    check_status("parity_next_good", 1, 3'b010);
    pop_one("parity_next_data");
    pulse_clr();
    check_status("parity_cleared", 0, 3'b000);
  endtask

  task automatic test_stop_err();
    send_bits(mk(8'h2A, odd_par(8'h2A), 1'b0), 0, 10, -1, -1);
    check_status("stop_bad", 0, 3'b001);
    pulse_clr();
    check_status("stop_cleared", 0, 3'b000);
  endtask

  task automatic test_glitch();
    send_bits(mk(8'hA5, odd_par(8'hA5), 1'b1), 0, 10, 3, -1);
    exp_q.push_back(8'hA5);
    check_status("glitch_count", 1, 3'b000);
    pop_one("glitch_data");
  endtask

  task automatic test_timeout();
    send_bits(mk(8'h3C, odd_par(8'h3C), 1'b1), 0, 4, -1, -1);
    check_status("timeout_pending", 0, 3'b000);
    repeat (TMO) @(negedge clk);
    check_status("timeout_fired", 0, 3'b001);
    pulse_clr();
    send_good(8'h3C);
    check_status("timeout_recover", 1, 3'b000);
    pop_one("timeout_recover_data");
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 9; i++) begin
      send_bits(mk(8'h10 + 8'(i), odd_par(8'h10 + 8'(i)), 1'b1), 0, 10, -1, -1);
      if (i < 8) exp_q.push_back(8'h10 + 8'(i));
    end
    check_status("ovf_full", 8, 3'b100);
    checks++;
    if (bus.data !== 8'h10) begin
      errors++; $display("FAIL ovf_head: data=%h, required 10", bus.data);
    end
    for (int i = 0; i < 8; i++) pop_one("ovf_drain");
    pulse_clr();
    check_status("ovf_cleared", 0, 3'b000);
    for (int i = 0; i < 8; i++) send_good(8'h80 + 8'(i));
    check_status("ovf2_full", 8, 3'b000);
    // Pop lands on the same edge as the ninth push.
    send_bits(mk(8'h99, odd_par(8'h99), 1'b1), 0, 10, -1, push_lat - 1);
    void'(exp_q.pop_front());
    exp_q.push_back(8'h99);
    check_status("ovf2_push_pop", 8, 3'b000);
    for (int i = 0; i < 8; i++) pop_one("ovf2_drain");
    check_status("ovf2_drained", 0, 3'b000);
  endtask

  task automatic test_reset_mid();
    send_good(8'h77);
    send_bits(mk(8'h1C, 1'b1, 1'b1), 0, 10, -1, -1);
    check_status("rst_mid_pre", 1, 3'b010);
    send_bits(mk(8'hF0, 1'b1, 1'b1), 0, 4, -1, -1);
    clrn = 1'b1;
    #1;
    check_status("rst_mid_async", 0, 3'b000);
    exp_q.delete();
    @(negedge clk);
    clrn = 1'b0;
    send_bits(mk(8'hF0, 1'b1, 1'b1), 5, 10, -1, -1);
    repeat (TMO + 50) @(negedge clk);
    check_status("rst_mid_tail", 0, 3'b000);
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_parity();
    test_stop_err();
    test_glitch();
    test_timeout();
    test_overflow();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
